led_display_arbiter: RTL



---
 rtl/led_display_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/led_display_arbiter.sv
// Round-robin owner of the shared 6-digit display; one dwell of HOLD_CYCLES per grant.
// Define LED_ARB_PRIO_EN to make source 0 urgent (preempts other owners).
module led_display_arbiter #(
    parameter int          NUM_SRC     = 4,
    parameter logic [23:0] HOLD_CYCLES = 24'd12000000,
    parameter int          CNT_W       = 24
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [NUM_SRC-1:0]    req,
    input  logic [NUM_SRC*24-1:0] src_data,
    input  logic [NUM_SRC*4-1:0]  src_dot,
    output logic [NUM_SRC-1:0]    grant,
    output logic [NUM_SRC-1:0]    served,
    output logic [23:0]           data_out,
    output logic [3:0]            dot_out,
    output logic                  busy
);
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 24'd1);
    localparam logic [23:0] BLANK_D = 24'hFFFFFF;
    localparam logic [3:0]  BLANK_P = 4'hF;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   own_q, own_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [NUM_SRC-1:0] served_q, served_d;
    logic [23:0]        data_q, data_d;
    logic [3:0]         dot_q, dot_d;
    logic [IDX_W-1:0]   rr_idx, win;
    logic               start;

    logic [23:0] data_a [NUM_SRC];
    logic [3:0]  dot_a  [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign data_a[g] = src_data[24*g +: 24];
        assign dot_a[g]  = src_dot[4*g +: 4];
    end

    // First requester strictly after the pointer, wrapping around.
    always_comb begin
        int  k;
        logic hit;
        rr_idx = '0;
        hit    = 1'b0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            k = (int'(ptr_q) + i) % NUM_SRC;
            if (!hit && req[IDX_W'(k)]) begin
                hit    = 1'b1;
                rr_idx = IDX_W'(k);
            end
        end
    end

`ifdef LED_ARB_PRIO_EN
    logic [IDX_W-1:0] save_q, save_d;
    assign win = req[0] ? '0 : rr_idx;
`else
    assign win = rr_idx;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        own_d    = own_q;
        grant_d  = grant_q;
        served_d = '0;
        data_d   = data_q;
        dot_d    = dot_q;
        start    = 1'b0;
`ifdef LED_ARB_PRIO_EN
        save_d   = save_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    start = 1'b1;
                end else begin
                    grant_d = '0;
                    data_d  = BLANK_D;
                    dot_d   = BLANK_P;
                end
            end
            HOLD: begin
                cnt_d  = cnt_q + 1'b1;
                data_d = data_a[own_q];
                dot_d  = dot_a[own_q];
                if (cnt_q == LAST) begin
                    served_d[own_q] = 1'b1;
                    if (|req) begin
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        grant_d = '0;
                        data_d  = BLANK_D;
                        dot_d   = BLANK_P;
                    end
                end
`ifdef LED_ARB_PRIO_EN
                // Preempted owner becomes the next round-robin candidate again.
                else if (req[0] && own_q != '0) begin
                    cnt_d   = '0;
                    own_d   = '0;
                    grant_d = '0;
                    grant_d[0] = 1'b1;
                    data_d  = data_a[0];
                    dot_d   = dot_a[0];
                    ptr_d   = save_q;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d      = HOLD;
            cnt_d        = '0;
            own_d        = win;
            grant_d      = '0;
            grant_d[win] = 1'b1;
            data_d       = data_a[win];
            dot_d        = dot_a[win];
`ifdef LED_ARB_PRIO_EN
            if (win != '0) begin
                ptr_d  = win;
                save_d = ptr_q;
            end
`else
            ptr_d = win;
`endif
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= IDX_W'(NUM_SRC - 1);
            own_q    <= '0;
            grant_q  <= '0;
            served_q <= '0;
            data_q   <= BLANK_D;
            dot_q    <= BLANK_P;
`ifdef LED_ARB_PRIO_EN
            save_q   <= IDX_W'(NUM_SRC - 1);
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            own_q    <= own_d;
            grant_q  <= grant_d;
            served_q <= served_d;
            data_q   <= data_d;
            dot_q    <= dot_d;
`ifdef LED_ARB_PRIO_EN
            save_q   <= save_d;
`endif
        end
    end

    assign grant    = grant_q;
    assign served   = served_q;
    assign data_out = data_q;
    assign dot_out  = dot_q;
    assign busy     = (state_q == HOLD);

endmodule
